// File: rtl/seg_display_scanner.sv
// seg_display_scanner
// Drives a 4-digit multiplexed seven-segment display from four BCD digits.
// One digit is lit at a time. Each digit gets BCD decoding and optional
// leading-zero suppression. The whole display can be blanked, steadily or
// blinking, and the blink phase can be restarted with blink_sync.
// Every output is registered. Each is computed from the next-state scan
// index and the current inputs, so anode, cathode and digit_sel always
// change on the same edge.
module seg_display_scanner #(
   parameter int DWELL_CYCLES      = 1,
   parameter int BLINK_HALF_CYCLES = 50,
   parameter bit ACTIVE_LOW        = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] val1,
   input  logic [3:0] val2,
   input  logic [3:0] val3,
   input  logic [3:0] val4,
   input  logic [1:0] blink_mode,
   input  logic       blink_sync,
   input  logic       lz_en,
   output logic [3:0] led_anodes,
   output logic [6:0] led_cathodes,
   output logic [1:0] digit_sel
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

   localparam logic [3:0] AN_OFF = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0] CA_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [1:0]    idx_q, idx_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          started_q, started_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   logic [3:0]    anodes_q, anodes_d;
   logic [6:0]    cath_q, cath_d;

   logic [3:0]    digit_val;
   logic          digit_lz_blank;
   logic          blank_all;
   logic [6:0]    seg_al;
   logic [3:0]    an_al;
   logic [6:0]    ca_al;

   // Scan index and dwell counter. The first edge after reset only arms the
   // scanner, so digit 0 gets its full dwell starting from that edge.
   always_comb begin
      idx_d     = idx_q;
      dwell_d   = dwell_q;
      started_d = 1'b1;
      if (started_q) begin
         if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
            dwell_d = '0;
            idx_d   = idx_q + 2'd1;
         end else begin
            dwell_d = dwell_q + DW'(1);
         end
      end
   end

   // Blink phase. The counter runs in every mode, and a sync pulse wins
   // over the terminal count.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (blink_sync) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_HALF_CYCLES - 1)) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   // Digit selection, leading-zero suppression, BCD decode and blanking
   // for the digit about to be driven.
   always_comb begin
      digit_val      = val4;
      digit_lz_blank = 1'b0;
      case (idx_d)
         2'd0: digit_val = val4;
         2'd1: begin
            digit_val      = val3;
            digit_lz_blank = lz_en && (val1 == 4'd0) && (val2 == 4'd0) && (val3 == 4'd0);
         end
         2'd2: begin
            digit_val      = val2;
            digit_lz_blank = lz_en && (val1 == 4'd0) && (val2 == 4'd0);
         end
         default: begin
            digit_val      = val1;
            digit_lz_blank = lz_en && (val1 == 4'd0);
         end
      endcase

      case (digit_val)
         4'd0:    seg_al = 7'h40;
         4'd1:    seg_al = 7'h79;
         4'd2:    seg_al = 7'h24;
         4'd3:    seg_al = 7'h30;
         4'd4:    seg_al = 7'h19;
         4'd5:    seg_al = 7'h12;
         4'd6:    seg_al = 7'h02;
         4'd7:    seg_al = 7'h78;
         4'd8:    seg_al = 7'h00;
         4'd9:    seg_al = 7'h10;
         default: seg_al = 7'h7F;
      endcase

      blank_all = (blink_mode == 2'b10) || ((blink_mode == 2'b01) && !blink_on_d);
      an_al     = blank_all ? 4'hF : ~(4'b0001 << idx_d);
      ca_al     = (blank_all || digit_lz_blank) ? 7'h7F : seg_al;
      anodes_d  = ACTIVE_LOW ? an_al : ~an_al;
      cath_d    = ACTIVE_LOW ? ca_al : ~ca_al;
   end

   // State and output registers. Reset is asynchronous, so the display goes
   // dark immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q       <= 2'd0;
         dwell_q     <= '0;
         started_q   <= 1'b0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         anodes_q    <= AN_OFF;
         cath_q      <= CA_OFF;
      end else begin
         idx_q       <= idx_d;
         dwell_q     <= dwell_d;
         started_q   <= started_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         anodes_q    <= anodes_d;
         cath_q      <= cath_d;
      end
   end

   assign led_anodes   = anodes_q;
   assign led_cathodes = cath_q;
   assign digit_sel    = idx_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner. The stimulus process pushes the
// expected display state for each edge, and a monitor pops and compares
// after every clock edge or reset assertion. The active-low instance's
// expectations are hand-computed. The active-high instance must show their
// bitwise inverse.
module tb_seg_display_scanner;

   typedef struct {
      logic [3:0] an;
      logic [6:0] ca;
      logic [1:0] sel;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] val1 = 4'd0, val2 = 4'd0, val3 = 4'd0, val4 = 4'd0;
   logic [1:0] blink_mode = 2'b00;
   logic       blink_sync = 1'b0;
   logic       lz_en = 1'b0;
   logic [3:0] an_l, an_h;
   logic [6:0] ca_l, ca_h;
   logic [1:0] sel_l, sel_h;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_pass = 0;
   logic [1:0] nidx = 2'd0;

   seg_display_scanner #(.DWELL_CYCLES(1), .BLINK_HALF_CYCLES(50), .ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .val1(val1), .val2(val2), .val3(val3), .val4(val4),
      .blink_mode(blink_mode), .blink_sync(blink_sync), .lz_en(lz_en),
      .led_anodes(an_l), .led_cathodes(ca_l), .digit_sel(sel_l));

   seg_display_scanner #(.DWELL_CYCLES(1), .BLINK_HALF_CYCLES(50), .ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst(rst), .val1(val1), .val2(val2), .val3(val3), .val4(val4),
      .blink_mode(blink_mode), .blink_sync(blink_sync), .lz_en(lz_en),
      .led_anodes(an_h), .led_cathodes(ca_h), .digit_sel(sel_h));

   always #5 clk = ~clk;

   task automatic push(input logic [3:0] an, input logic [6:0] ca, input logic [1:0] sel);
      exp_t e;
      e.an  = an;
      e.ca  = ca;
      e.sel = sel;
      sb.push_back(e);
   endtask

   // One scanned edge: c3..c0 are the expected cathodes for digits 3..0.
   task automatic scan_cycle(input logic [6:0] c3, input logic [6:0] c2,
                             input logic [6:0] c1, input logic [6:0] c0, input bit blank);
      logic [6:0] c;
      case (nidx)
         2'd0:    c = c0;
         2'd1:    c = c1;
         2'd2:    c = c2;
         default: c = c3;
      endcase
      if (blank) push(4'hF, 7'h7F, nidx);
      else       push(~(4'b0001 << nidx), c, nidx);
      @(negedge clk);
      nidx = nidx + 2'd1;
   endtask

   task automatic set_vals(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
      val1 = a; val2 = b; val3 = c; val4 = d;
   endtask

   // Monitor: compare after each clock edge and on every asynchronous reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (an_l === e.an && ca_l === e.ca && sel_l === e.sel &&
                an_h === ~e.an && ca_h === ~e.ca && sel_h === e.sel) begin
               n_pass++;
               $display("chk %0d t=%0t an=%b ca=%h sel=%0d ok", n_checks, $time, an_l, ca_l, sel_l);
            end else begin
               $display("FAIL display chk %0d t=%0t: got an=%b ca=%h sel=%0d (inv an=%b ca=%h sel=%0d), required an=%b ca=%h sel=%0d",
                        n_checks, $time, an_l, ca_l, sel_l, an_h, ca_h, sel_h, e.an, e.ca, e.sel);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit blank;
      // Reset held across an edge: everything dark.
      @(negedge clk);
      push(4'hF, 7'h7F, 2'd0);
      @(negedge clk);

      // Basic scan of 1,2,3,4.
      set_vals(4'd1, 4'd2, 4'd3, 4'd4);
      rst  = 1'b0;
      nidx = 2'd0;
      for (int i = 0; i < 7; i++) scan_cycle(7'h79, 7'h24, 7'h30, 7'h19, 1'b0);

      // Asynchronous reset mid-scan (idx = 2): dark immediately, restart at digit 0.
      #2;
      push(4'hF, 7'h7F, 2'd0);
      rst = 1'b1;
      @(negedge clk);
      push(4'hF, 7'h7F, 2'd0);
      @(negedge clk);
      rst  = 1'b0;
      nidx = 2'd0;
      for (int i = 0; i < 2; i++) scan_cycle(7'h79, 7'h24, 7'h30, 7'h19, 1'b0);

      // Leading-zero suppression.
      set_vals(4'd0, 4'd0, 4'd4, 4'd0); lz_en = 1'b1;
      for (int i = 0; i < 4; i++) scan_cycle(7'h7F, 7'h7F, 7'h19, 7'h40, 1'b0);
      lz_en = 1'b0;
      for (int i = 0; i < 4; i++) scan_cycle(7'h40, 7'h40, 7'h19, 7'h40, 1'b0);
      set_vals(4'd0, 4'd0, 4'd0, 4'd0); lz_en = 1'b1;
      for (int i = 0; i < 4; i++) scan_cycle(7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0);
      set_vals(4'd0, 4'd5, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) scan_cycle(7'h7F, 7'h12, 7'h40, 7'h40, 1'b0);
      set_vals(4'd6, 4'd7, 4'd8, 4'd9);
      for (int i = 0; i < 4; i++) scan_cycle(7'h02, 7'h78, 7'h00, 7'h10, 1'b0);
      lz_en = 1'b0;

      // Invalid code blanks the segments but still drives the anode.
      set_vals(4'd1, 4'd2, 4'd3, 4'hC);
      for (int i = 0; i < 4; i++) scan_cycle(7'h79, 7'h24, 7'h30, 7'h7F, 1'b0);
      // Mode 10 blanks the display while the scan keeps going; mode 11 is steady.
      blink_mode = 2'b10;
      for (int i = 0; i < 4; i++) scan_cycle(7'h79, 7'h24, 7'h30, 7'h7F, 1'b1);
      blink_mode = 2'b11;
      for (int i = 0; i < 4; i++) scan_cycle(7'h79, 7'h24, 7'h30, 7'h7F, 1'b0);

      // Blink from a fresh reset. Edges 50-99, 150-159, 210-259 and 360-361
      // are dark. A sync at edge 160 relights the display. A sync at edge
      // 310, which is also a terminal count, keeps it lit.
      rst = 1'b1;
      push(4'hF, 7'h7F, 2'd0);
      @(negedge clk);
      set_vals(4'd1, 4'd2, 4'd3, 4'd4);
      blink_mode = 2'b01;
      rst  = 1'b0;
      nidx = 2'd0;
      for (int e = 1; e <= 361; e++) begin
         blink_sync = (e == 160) || (e == 310);
         blank = (e >= 50 && e < 100) || (e >= 150 && e < 160) ||
                 (e >= 210 && e < 260) || (e >= 360);
         scan_cycle(7'h79, 7'h24, 7'h30, 7'h19, blank);
      end
      blink_sync = 1'b0;

      @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
